// File: rtl/weight_fetch_pkg.sv
// Shared types and layer geometry for the weight fetch sequencer.
// Layer codes, counter width, FSM encoding, fan/node helpers.
package weight_fetch_pkg;

  localparam int WEIGHT_COUNTER_WIDTH = 11;

  typedef logic [WEIGHT_COUNTER_WIDTH-1:0] wcnt_t;

  localparam logic [1:0] LAYER_NONE    = 2'b00;
  localparam logic [1:0] LAYER_HIDDEN1 = 2'b01;
  localparam logic [1:0] LAYER_HIDDEN2 = 2'b10;
  localparam logic [1:0] LAYER_OUTPUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Fan-in of one node including its bias word.
  function automatic wcnt_t layer_fan(
    input logic [1:0] layer,
    input int         ni,
    input int         n1,
    input int         n2
  );
    wcnt_t f;
    f = '0;
    case (layer)
      LAYER_HIDDEN1: f = wcnt_t'(ni + 1);
      LAYER_HIDDEN2: f = wcnt_t'(n1 + 1);
      LAYER_OUTPUT:  f = wcnt_t'(n2 + 1);
      default:       f = '0;
    endcase
    return f;
  endfunction

  // Number of nodes whose weights live in the layer.
  function automatic wcnt_t layer_nodes(
    input logic [1:0] layer,
    input int         n1,
    input int         n2,
    input int         no
  );
    wcnt_t n;
    n = '0;
    case (layer)
      LAYER_HIDDEN1: n = wcnt_t'(n1);
      LAYER_HIDDEN2: n = wcnt_t'(n2);
      LAYER_OUTPUT:  n = wcnt_t'(no);
      default:       n = '0;
    endcase
    return n;
  endfunction

  // Total weight words in the layer.
  function automatic wcnt_t layer_total(
    input logic [1:0] layer,
    input int         ni,
    input int         n1,
    input int         n2,
    input int         no
  );
    int t;
    t = int'(layer_fan(layer, ni, n1, n2))
      * int'(layer_nodes(layer, n1, n2, no));
    return wcnt_t'(t);
  endfunction

endpackage

// File: rtl/weight_fetch_if.sv
// Weight RAM request/response bus plus the downstream word stream.
// master = sequencer side, slave = RAM + consumer side.
interface weight_fetch_if
  import weight_fetch_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LAYER_WIDTH    = 2,
  parameter int NODE_IDX_WIDTH = 6
);

  logic                      o_ram_enable;
  logic                      o_rw_select;
  logic [LAYER_WIDTH-1:0]    o_ram_layer;
  wcnt_t                     o_ram_addr;

  logic                      i_weight_valid;
  logic [LAYER_WIDTH-1:0]    i_weight_layer;
  wcnt_t                     i_weight_addr;
  logic [DATA_WIDTH-1:0]     i_weight;

  logic                      o_valid;
  logic                      i_ready;
  logic [DATA_WIDTH-1:0]     o_weight;
  logic [NODE_IDX_WIDTH-1:0] o_node_idx;
  logic                      o_last_in_node;
  logic                      o_last;

  modport master (
    output o_ram_enable,
    output o_rw_select,
    output o_ram_layer,
    output o_ram_addr,
    input  i_weight_valid,
    input  i_weight_layer,
    input  i_weight_addr,
    input  i_weight,
    output o_valid,
    input  i_ready,
    output o_weight,
    output o_node_idx,
    output o_last_in_node,
    output o_last
  );

  modport slave (
    input  o_ram_enable,
    input  o_rw_select,
    input  o_ram_layer,
    input  o_ram_addr,
    output i_weight_valid,
    output i_weight_layer,
    output i_weight_addr,
    output i_weight,
    input  o_valid,
    output i_ready,
    input  o_weight,
    input  o_node_idx,
    input  o_last_in_node,
    input  o_last
  );

endinterface

// File: rtl/weight_fetch_fifo.sv
// Small synchronous FIFO holding {tags, weight} response words.
// Exposes occupancy so the issuer can enforce its credit limit.
module weight_fetch_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_count = cnt_q;
  assign o_data  = mem_q[rptr_q];

  // Pointer and occupancy update; a full push or empty pop is dropped.
  always_comb begin
    do_push = i_push && !o_full;
    do_pop  = i_pop && !o_empty;
    wptr_d  = wptr_q + PW'(do_push);
    rptr_d  = rptr_q + PW'(do_pop);
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array, no reset needed since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= i_data;
  end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Weight RAM read initiator: walks a layer node-major, streams words out.
// Optional RESP_CHECK_EN adds a sticky response layer/address mismatch flag.
module weight_fetch_sequencer
  import weight_fetch_pkg::*;
#(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int NODE_IDX_WIDTH                = 6,
  parameter int FIFO_DEPTH                    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [LAYER_WIDTH-1:0] i_layer,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  weight_fetch_if.master         bus
);

  localparam int TAG_W = NODE_IDX_WIDTH + 2;
  localparam int FW    = TAG_W + DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  state_t                    state_q, state_d;
  logic [LAYER_WIDTH-1:0]    layer_q, layer_d;
  wcnt_t                     addr_q, addr_d;
  wcnt_t                     k_q, k_d;
  logic [NODE_IDX_WIDTH-1:0] node_q, node_d;
  logic                      inflight_q, inflight_d;
  logic [TAG_W-1:0]          tag_q, tag_d;

  wcnt_t            fan, addr_last;
  logic             credit, issue, start_acc;
  logic             last_k, last_a;
  logic [TAG_W-1:0] tag_now;
  logic [OCC_W-1:0] occ;

  logic             push, pop;
  logic [FW-1:0]    fifo_dout;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;

  assign fan = layer_fan(2'(layer_q),
    NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1,
    NUMBER_OF_HIDDEN_NODE_LAYER_2);
  assign addr_last = layer_total(2'(layer_q),
    NUMBER_OF_INPUT_NODE,
    NUMBER_OF_HIDDEN_NODE_LAYER_1,
    NUMBER_OF_HIDDEN_NODE_LAYER_2,
    NUMBER_OF_OUTPUT_NODE) - 1'b1;

  // Issue gating: buffered words plus an in-flight read must leave room.
  always_comb begin
    occ       = {1'b0, fifo_count} + OCC_W'(inflight_q);
    credit    = occ < OCC_W'(FIFO_DEPTH);
    issue     = (state_q == ST_FETCH) && credit;
    start_acc = (state_q == ST_IDLE) && i_start
             && (2'(i_layer) != LAYER_NONE);
    last_k    = (k_q == fan - 1'b1);
    last_a    = (addr_q == addr_last);
    tag_now   = {node_q, last_k, last_a};
  end

  // Walk FSM and address/node counters.
  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    addr_d     = addr_q;
    k_d        = k_q;
    node_d     = node_q;
    inflight_d = issue;
    tag_d      = issue ? tag_now : tag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_FETCH;
          layer_d = i_layer;
          addr_d  = '0;
          k_d     = '0;
          node_d  = '0;
        end
      end
      ST_FETCH: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (last_k) begin
            k_d    = '0;
            node_d = node_q + 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
          if (last_a) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      layer_q    <= '0;
      addr_q     <= '0;
      k_q        <= '0;
      node_q     <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      node_q     <= node_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  assign push = bus.i_weight_valid
             && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));
  assign pop  = !fifo_empty && bus.i_ready;

  weight_fetch_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_data  ({tag_q, bus.i_weight}),
    .i_pop   (pop),
    .o_data  (fifo_dout),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (fifo_count)
  );

  assign o_busy = (state_q != ST_IDLE);
  assign o_done = (state_q == ST_DONE);

  assign bus.o_ram_enable = issue;
  assign bus.o_rw_select  = 1'b1;
  assign bus.o_ram_layer  = layer_q;
  assign bus.o_ram_addr   = addr_q;

  assign bus.o_valid = !fifo_empty;
  assign {bus.o_node_idx,
          bus.o_last_in_node,
          bus.o_last,
          bus.o_weight} = fifo_dout;

`ifdef RESP_CHECK_EN
  wcnt_t exp_addr_q, exp_addr_d;
  logic  err_q, err_d;

  // Sticky mismatch between echoed and expected layer/address.
  always_comb begin
    exp_addr_d = issue ? addr_q : exp_addr_q;
    err_d      = err_q;
    if (start_acc) begin
      err_d = 1'b0;
    end else if (push
      && ((bus.i_weight_layer != layer_q)
      || (bus.i_weight_addr != exp_addr_q))) begin
      err_d = 1'b1;
    end
  end

  // Response check registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      err_q      <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule
